// File: rtl/accumulator_scheduler.sv
// Round-robin arbiter granting one requester at a time a burst
// into a shared accumulator, then holding the sum until taken.
module accumulator_scheduler #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int LEN_W = 8
) (
  input  logic                       i_CLK,
  input  logic                       i_RESET,
  input  logic [N_REQ-1:0]           i_REQ,
  input  logic [N_REQ*LEN_W-1:0]     i_LEN,
  input  logic [N_REQ*WIDTH-1:0]     i_DATA,
  input  logic [N_REQ-1:0]           i_VALID,
  output logic [N_REQ-1:0]           o_READY,
  output logic [N_REQ-1:0]           o_GRANT,
  output logic [WIDTH-1:0]           o_RESULT,
  output logic [$clog2(N_REQ)-1:0]   o_RESULT_ID,
  output logic                       o_RESULT_VALID,
  input  logic                       i_RESULT_READY,
  output logic                       o_OVERFLOW,
  output logic                       o_BUSY
);

  localparam int ID_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [N_REQ-1:0]  ready_q, ready_d;
  logic [ID_W-1:0]   idx_q, idx_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;

  logic              found;
  logic [ID_W-1:0]   win;
  logic [LEN_W-1:0]  win_len;
  logic [WIDTH-1:0]  cur_data;
  logic [WIDTH:0]    sum;
  logic [LEN_W-1:0]  cnt_nxt;
  logic              accept;

  // Round-robin pick: first requester after the last owner, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!found && i_REQ[(int'(last_q) + i) % N_REQ]) begin
        found = 1'b1;
        win   = ID_W'((int'(last_q) + i) % N_REQ);
      end
    end
  end

  // Beat datapath: selected lane, carry-extended sum, beat count.
  always_comb begin
    win_len  = i_LEN[int'(win)*LEN_W +: LEN_W];
    cur_data = i_DATA[int'(idx_q)*WIDTH +: WIDTH];
    sum      = {1'b0, acc_q} + {1'b0, cur_data};
    cnt_nxt  = cnt_q + LEN_W'(1);
    accept   = (state_q == ACCUM) && i_VALID[idx_q] && ready_q[idx_q];
  end

  // Next-state logic for the grant/accumulate/result sequence.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ready_d = ready_q;
    idx_d   = idx_q;
    last_d  = last_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          idx_d   = win;
          len_d   = win_len;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          grant_d = N_REQ'(1) << win;
          busy_d  = 1'b1;
          if (win_len != '0) begin
            state_d = ACCUM;
            ready_d = N_REQ'(1) << win;
          end else begin
            state_d = DONE;
            valid_d = 1'b1;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d = sum[WIDTH-1:0];
          ovf_d = ovf_q | sum[WIDTH];
          cnt_d = cnt_nxt;
          if (cnt_nxt == len_q) begin
            state_d = DONE;
            ready_d = '0;
            valid_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (i_RESULT_READY) begin
          state_d = IDLE;
          last_d  = idx_q;
          grant_d = '0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        ready_d = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops any partial burst.
  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      state_q <= IDLE;
      grant_q <= '0;
      ready_q <= '0;
      idx_q   <= '0;
      last_q  <= ID_W'(N_REQ - 1);
      len_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ready_q <= ready_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign o_READY        = ready_q;
  assign o_GRANT        = grant_q;
  assign o_RESULT       = acc_q;
  assign o_RESULT_ID    = idx_q;
  assign o_RESULT_VALID = valid_q;
  assign o_OVERFLOW     = ovf_q;
  assign o_BUSY         = busy_q;

endmodule

// File: tb/tb_accumulator_scheduler.sv
// Directed bench for accumulator_scheduler: bursts, round-robin,
// overflow, zero length, backpressure, gaps and mid-burst reset.
module tb_accumulator_scheduler;

  logic         clk;
  logic         rst;
  logic [3:0]   req;
  logic [31:0]  len;
  logic [127:0] data;
  logic [3:0]   valid;
  logic [3:0]   ready;
  logic [3:0]   grant;
  logic [31:0]  result;
  logic [1:0]   rid;
  logic         rvalid;
  logic         rready;
  logic         ovf;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int rdy0_n = 0;
  int base;

  accumulator_scheduler #(
    .N_REQ(4),
    .WIDTH(32),
    .LEN_W(8)
  ) dut (
    .i_CLK         (clk),
    .i_RESET       (rst),
    .i_REQ         (req),
    .i_LEN         (len),
    .i_DATA        (data),
    .i_VALID       (valid),
    .o_READY       (ready),
    .o_GRANT       (grant),
    .o_RESULT      (result),
    .o_RESULT_ID   (rid),
    .o_RESULT_VALID(rvalid),
    .i_RESULT_READY(rready),
    .o_OVERFLOW    (ovf),
    .o_BUSY        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (ready[0]) rdy0_n++;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_len(int k, logic [7:0] v);
    len[k*8 +: 8] = v;
  endtask

  task automatic set_data(int k, logic [31:0] v);
    data[k*32 +: 32] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic beat(int k, logic [31:0] v);
    int t;
    set_data(k, v);
    valid[k] = 1'b1;
    t = 0;
    while (!ready[k] && t < 50) begin
      tick();
      t++;
    end
    if (!ready[k]) chk("ready_timeout", 0, 1);
    tick();
  endtask

  task automatic gap(int k);
    valid[k] = 1'b0;
    tick();
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!rvalid && t < 50) begin
      tick();
      t++;
    end
    if (!rvalid) chk("done_timeout", 0, 1);
  endtask

  task automatic handshake();
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("hs_grant", grant, 0);
    chk("hs_busy", busy, 0);
    chk("hs_valid", rvalid, 0);
  endtask

  initial begin
    rst    = 1'b1;
    req    = '0;
    len    = '0;
    data   = '0;
    valid  = '0;
    rready = 1'b0;
    do_reset();

    chk("rst_grant", grant, 0);
    chk("rst_ready", ready, 0);
    chk("rst_result", result, 0);
    chk("rst_id", rid, 0);
    chk("rst_valid", rvalid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", busy, 0);

    // single burst 5+7+9
    base = rdy0_n;
    req = 4'b0001;
    set_len(0, 3);
    beat(0, 5);
    chk("t1_grant", grant, 4'b0001);
    chk("t1_busy", busy, 1);
    req = 4'b0000;
    beat(0, 7);
    beat(0, 9);
    valid = '0;
    wait_done();
    chk("t1_result", result, 21);
    chk("t1_id", rid, 0);
    chk("t1_ovf", ovf, 0);
    chk("t1_ready", ready, 0);
    chk("t1_rdy_cycles", rdy0_n - base, 3);
    handshake();

    // round-robin from fresh reset
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      set_len(k, 1);
      set_data(k, 32'(10 + k));
    end
    valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_done();
      chk("rr_id", rid, n % 4);
      chk("rr_grant", grant, 4'b0001 << (n % 4));
      chk("rr_result", result, 10 + (n % 4));
      handshake();
    end
    req = '0;
    valid = '0;

    // carry out of the top bit
    req = 4'b0100;
    set_len(2, 2);
    beat(2, 32'hFFFF_FFE0);
    req = '0;
    beat(2, 32'h0000_0040);
    valid = '0;
    wait_done();
    chk("ov_result", result, 32'h0000_0020);
    chk("ov_flag", ovf, 1);
    chk("ov_id", rid, 2);
    handshake();

    // zero length, result held under backpressure
    req = 4'b1001;
    set_len(3, 0);
    set_len(0, 2);
    tick();
    chk("z_valid", rvalid, 1);
    chk("z_result", result, 0);
    chk("z_ovf", ovf, 0);
    chk("z_id", rid, 3);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_valid", rvalid, 1);
      chk("bp_result", result, 0);
      chk("bp_id", rid, 3);
      chk("bp_grant", grant, 4'b1000);
      chk("bp_ready", ready, 0);
    end
    req = '0;
    handshake();

    // gapped valid, dropped request, foreign traffic ignored
    set_data(0, 1000);
    valid[0] = 1'b1;
    req = 4'b0010;
    set_len(1, 4);
    beat(1, 1);
    req = '0;
    gap(1);
    beat(1, 2);
    gap(1);
    set_len(1, 1);
    beat(1, 3);
    gap(1);
    beat(1, 4);
    set_data(1, 100);
    tick();
    tick();
    chk("g_result", result, 10);
    chk("g_valid", rvalid, 1);
    chk("g_id", rid, 1);
    chk("g_ready", ready, 0);
    valid = '0;
    handshake();

    // reset in the middle of a burst
    req = 4'b0110;
    set_len(2, 4);
    beat(2, 50);
    beat(2, 50);
    valid = '0;
    chk("mr_pre_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("mr_grant", grant, 0);
    chk("mr_ready", ready, 0);
    chk("mr_result", result, 0);
    chk("mr_busy", busy, 0);
    chk("mr_valid", rvalid, 0);
    tick();
    rst = 1'b0;
    req = 4'b0101;
    set_len(0, 1);
    beat(0, 7);
    valid = '0;
    req = '0;
    wait_done();
    chk("mr_next_id", rid, 0);
    chk("mr_next_res", result, 7);
    handshake();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/accumulator_scheduler.md
ACCUMULATOR_SCHEDULER -- requirements
Module: accumulator_scheduler

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the accumulator (2..8).
REQ-002 Parameter WIDTH, default 32, data and accumulator width.
REQ-003 Parameter LEN_W, default 8, burst-length field width per requester.
REQ-004 Port i_CLK  in  1  sole clock; all state updates on its rising edge.
REQ-005 Port i_RESET  in  1  reset; asynchronous, active-high.
REQ-006 Port i_REQ  in  N_REQ  per-requester burst request, level-sensitive.
REQ-007 Port i_LEN  in  N_REQ*LEN_W  per-requester burst length in words; slice k at bits [k*LEN_W +: LEN_W].
REQ-008 Port i_DATA  in  N_REQ*WIDTH  per-requester data word; slice k at bits [k*WIDTH +: WIDTH].
REQ-009 Port i_VALID  in  N_REQ  per-requester data valid.
REQ-010 Port o_READY  out  N_REQ  data ready; only the granted bit may be set, and only in ACCUM.
REQ-011 Port o_GRANT  out  N_REQ  one-hot owner of the accumulator; all-zero in IDLE.
REQ-012 Port o_RESULT  out  WIDTH  accumulated sum of the completed burst.
REQ-013 Port o_RESULT_ID  out  clog2(N_REQ)  index of the requester that owns o_RESULT.
REQ-014 Port o_RESULT_VALID  out  1  result handshake valid.
REQ-015 Port i_RESULT_READY  in  1  result handshake ready.
REQ-016 Port o_OVERFLOW  out  1  set when any addition in the burst carried out of WIDTH; valid with o_RESULT_VALID.
REQ-017 Port o_BUSY  out  1  high in any state other than IDLE.

Function
REQ-018 The block SHALL implement an FSM with three states: IDLE, ACCUM and DONE.
REQ-019 In IDLE with any i_REQ bit set, the block SHALL select a winner on the next edge by round-robin: search from index (last_owner+1) mod N_REQ upward with wrap-around.
REQ-020 On grant, the block SHALL latch the winner's index and its i_LEN, clear the accumulator to 0, clear the overflow flag and the beat counter, and set o_GRANT.
REQ-021 On grant, the FSM SHALL go to ACCUM if the latched length is nonzero, else to DONE with o_RESULT=0.
REQ-022 In ACCUM, o_READY[g] SHALL be 1, where g is the granted index; a beat is accepted when i_VALID[g] and o_READY[g] are both high on an edge.
REQ-023 Each accepted beat SHALL add i_DATA slice g to the accumulator modulo 2^WIDTH, OR the carry-out into the overflow flag, and increment the beat counter.
REQ-024 When the accepted beat is number latched_len, the FSM SHALL enter DONE on that edge, and o_READY SHALL be 0 from the next cycle.
REQ-025 i_VALID, i_DATA and i_REQ of non-granted requesters SHALL be ignored; deasserting i_REQ[g] mid-burst SHALL NOT abort the burst.
REQ-026 Changes to i_LEN after the grant SHALL have no effect on the burst in progress.
REQ-027 In DONE, o_RESULT_VALID SHALL be 1, and o_RESULT, o_RESULT_ID and o_OVERFLOW SHALL stay stable until i_RESULT_READY is sampled high.
REQ-028 On the DONE handshake edge, the block SHALL set last_owner to g, clear o_GRANT and return to IDLE. A new grant is possible no earlier than the following edge, so there is one IDLE cycle between bursts.
REQ-029 A requester whose i_REQ is still high after its burst SHALL be served again only after every other requesting index has been considered.

Reset
REQ-030 While i_RESET is high, the block SHALL immediately force: state IDLE, o_GRANT=0, o_READY=0, o_RESULT=0, o_RESULT_ID=0, o_RESULT_VALID=0, o_OVERFLOW=0, o_BUSY=0, last_owner=N_REQ-1 (so requester 0 has first priority).
REQ-031 Reset asserted mid-burst or in DONE SHALL discard the partial sum and the pending result; no handshake SHALL complete in that cycle.

Verification
REQ-032 Single burst: after reset, i_REQ=0001, LEN0=3, data 5, 7, 9 with VALID always high -> o_RESULT=21, ID=0, OVERFLOW=0; o_READY[0] high for exactly 3 cycles.
REQ-033 Round-robin: i_REQ=1111 held, all LEN=1 -> grant order 0,1,2,3,0; each result ID matches its grant.
REQ-034 Wrap/overflow: LEN=2, data 0xFFFFFFE0 then 0x00000040 -> o_RESULT=0x00000020, OVERFLOW=1.
REQ-035 Zero length and backpressure: LEN=0 -> DONE directly with o_RESULT=0; hold i_RESULT_READY low 5 cycles -> outputs stable, no new grant.
REQ-036 Gapped VALID and mid-burst drop: LEN=4 with VALID toggling and i_REQ dropped after the first beat -> all 4 beats summed, no extra beats accepted.
REQ-037 Reset mid-burst: assert i_RESET after 2 of 4 beats -> all outputs 0 immediately; the next grant goes to requester 0 and starts from a sum of 0.
